pmem_loader: RTL and testbench

//  Writer side of the program memory: receives a framed byte stream (debug/UART link),

---
 rtl/pmem_loader_if.sv | 29 ++
 rtl/pmem_loader.sv | 160 ++++++++++++++++
 tb/tb_pmem_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_loader_if.sv
// Byte-stream input and PMEM write port of the program-memory loader.
// The master side drives the stream and observes the writes.
// The slave side (the loader) accepts bytes and drives the write strobe, address and data.
interface pmem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        pmem_we;
    logic [31:0] pmem_waddr;
    logic [31:0] pmem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  pmem_we,
        input  pmem_waddr,
        input  pmem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output pmem_we,
        output pmem_waddr,
        output pmem_wdata
    );
endinterface

// File: rtl/pmem_loader.sv
// Framed byte stream -> little-endian 32-bit PMEM words; holds the CPU while a frame loads.
// Latency: pmem_we one cycle after the 4th payload byte; status pulse one cycle after CSUM byte.
// Backpressure: rx_ready drops only in the single WRITE cycle; rx_valid low simply stalls the FSM.
module pmem_loader #(
    parameter int          ADDR_W = 15,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    pmem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_CNT, S_DATA, S_WRITE, S_CSUM, S_ERR
    } state_t;

    // One past the last valid word index of the PMEM array.
    localparam logic [32:0] WORD_LIMIT = 33'd1 << ADDR_W;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  sum_q, sum_d;
    logic        done_q, done_d;
    logic        cerr_q, cerr_d;

    logic        accept;
    logic [31:0] addr_nxt;
    logic [15:0] cnt_nxt;
    logic [31:0] word_nxt;
    logic        range_bad;

    // Handshake is derived from state directly so it does not loop through the FSM block.
    assign bus.rx_ready = (state_q != S_WRITE);
    assign accept       = bus.rx_valid && (state_q != S_WRITE);

    // Little-endian shift-in: the first byte received ends up in bits [7:0].
    assign addr_nxt = {bus.rx_data, addr_q[31:8]};
    assign cnt_nxt  = {bus.rx_data, cnt_q[15:8]};
    assign word_nxt = {bus.rx_data, word_q[31:8]};

    // Last word of the frame must still fall inside the array; no wrap-around allowed.
    assign range_bad = ({3'b000, addr_q[31:2]} + {17'd0, cnt_nxt}) > WORD_LIMIT;

    assign cpu_hold   = (state_q != S_IDLE) && (state_q != S_ERR);
    assign load_done  = done_q;
    assign load_error = cerr_q || (state_q == S_ERR);

    // State and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            addr_q     <= 32'd0;
            cnt_q      <= 16'd0;
            word_q     <= 32'd0;
            sum_q      <= 8'd0;
            done_q     <= 1'b0;
            cerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            done_q     <= done_d;
            cerr_q     <= cerr_d;
        end
    end

    // Frame parser: next state, field assembly and the PMEM write port.
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        sum_d          = sum_q;
        done_d         = 1'b0;
        cerr_d         = 1'b0;
        bus.pmem_we    = 1'b0;
        bus.pmem_waddr = 32'd0;
        bus.pmem_wdata = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (accept && (bus.rx_data == SYNC)) begin
                    state_d    = S_ADDR;
                    byte_cnt_d = 2'd0;
                    sum_d      = 8'd0;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d     = addr_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = (addr_nxt[1:0] != 2'b00) ? S_ERR : S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_d      = cnt_nxt;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        if (range_bad) begin
                            state_d = S_ERR;
                        end else if (cnt_nxt == 16'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = word_nxt;
                    sum_d      = sum_q + bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                bus.pmem_we    = 1'b1;
                bus.pmem_waddr = addr_q;
                bus.pmem_wdata = word_q;
                addr_d         = addr_q + 32'd4;
                cnt_d          = cnt_q - 16'd1;
                state_d        = (cnt_q == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    done_d  = (bus.rx_data == sum_q);
                    cerr_d  = (bus.rx_data != sum_q);
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: frame load, checksum, alignment/range aborts, reset, stalls.
// Bytes are driven on the falling edge; outputs are sampled on the falling edge.
// A falling-edge monitor tallies writes, pulses and ready-low cycles for delta checks.
module tb_pmem_loader;

    logic clk;
    logic reset;
    logic cpu_hold;
    logic load_done;
    logic load_error;

    pmem_loader_if bus ();

    pmem_loader #(.ADDR_W(15), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_n = 0;
    int err_n = 0;

    int wr_n      = 0;
    int done_n    = 0;
    int lerr_n    = 0;
    int both_n    = 0;
    int rdy_low_n = 0;
    int rdy_bad_n = 0;

    // Observed activity, sampled on the falling edge outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pmem_we) wr_n++;
            if (load_done) done_n++;
            if (load_error) lerr_n++;
            if (load_done && load_error) both_n++;
            if (!bus.rx_ready) rdy_low_n++;
            if (bus.rx_ready == bus.pmem_we) rdy_bad_n++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte at a falling edge and return at the falling edge after its handshake.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8 && !bus.rx_ready; i++) @(negedge clk);
        if (!bus.rx_ready) begin
            vec_n++;
            err_n++;
            $error("FAIL rx_ready_timeout: observed 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Frame 1: two words at 0x100; checksum byte supplied by caller.
    task automatic frame1(input logic [7:0] cs, input logic good);
        send(8'hA5);
        chk("hold_after_sync", cpu_hold, 1'b1);
        send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        send(8'h02); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22);
        chk("we_before_4th", bus.pmem_we, 1'b0);
        send(8'h11);
        chk("we0", bus.pmem_we, 1'b1);
        chk("waddr0", bus.pmem_waddr, 32'h0000_0100);
        chk("wdata0", bus.pmem_wdata, 32'h1122_3344);
        chk("rdy_in_write0", bus.rx_ready, 1'b0);
        send(8'hDD); send(8'hCC); send(8'hBB); send(8'hAA);
        chk("we1", bus.pmem_we, 1'b1);
        chk("waddr1", bus.pmem_waddr, 32'h0000_0104);
        chk("wdata1", bus.pmem_wdata, 32'hAABB_CCDD);
        chk("hold_before_csum", cpu_hold, 1'b1);
        send(cs);
        chk("done_pulse", load_done, good);
        chk("error_pulse", load_error, !good);
        chk("hold_after_csum", cpu_hold, 1'b0);
        idle();
        @(negedge clk);
        chk("done_one_cycle", load_done, 1'b0);
        chk("error_one_cycle", load_error, 1'b0);
    endtask

    int w0, d0, e0, r0;

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.rx_ready, 1'b1);
        chk("rst_we", bus.pmem_we, 1'b0);
        chk("rst_waddr", bus.pmem_waddr, 32'd0);
        chk("rst_hold", cpu_hold, 1'b0);
        chk("rst_done", load_done, 1'b0);
        chk("rst_error", load_error, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // 1: good frame.
        w0 = wr_n; d0 = done_n; e0 = lerr_n;
        frame1(8'hB8, 1'b1);
        chk("t1_writes", wr_n - w0, 2);
        chk("t1_done", done_n - d0, 1);
        chk("t1_err", lerr_n - e0, 0);

        // 2: bad checksum, writes still land.
        w0 = wr_n; d0 = done_n; e0 = lerr_n;
        frame1(8'hB9, 1'b0);
        chk("t2_writes", wr_n - w0, 2);
        chk("t2_done", done_n - d0, 0);
        chk("t2_err", lerr_n - e0, 1);

        // 3: misaligned address aborts after 4th address byte.
        w0 = wr_n; d0 = done_n; e0 = lerr_n;
        send(8'hA5);
        send(8'h02); send(8'h01); send(8'h00); send(8'h00);
        chk("t3_err_pulse", load_error, 1'b1);
        chk("t3_hold", cpu_hold, 1'b0);
        send(8'h02); send(8'h00); send(8'h44); send(8'h33);
        idle();
        @(negedge clk);
        chk("t3_hold_after", cpu_hold, 1'b0);
        chk("t3_writes", wr_n - w0, 0);
        chk("t3_err", lerr_n - e0, 1);
        chk("t3_done", done_n - d0, 0);

        // 4a: zero-count frame.
        w0 = wr_n; d0 = done_n;
        send(8'hA5);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        send(8'h00); send(8'h00);
        chk("t4_hold_csum", cpu_hold, 1'b1);
        send(8'h00);
        chk("t4_done", load_done, 1'b1);
        idle();
        chk("t4_writes", wr_n - w0, 0);

        // 4b: last word exactly at the top of the array is allowed.
        w0 = wr_n; d0 = done_n;
        send(8'hA5);
        send(8'hFC); send(8'hFF); send(8'h01); send(8'h00);
        send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("t4b_waddr", bus.pmem_waddr, 32'h0001_FFFC);
        chk("t4b_wdata", bus.pmem_wdata, 32'h0403_0201);
        send(8'h0A);
        chk("t4b_done", load_done, 1'b1);
        idle();
        chk("t4b_writes", wr_n - w0, 1);

        // 4c: one word past the top aborts after the count.
        w0 = wr_n; e0 = lerr_n;
        send(8'hA5);
        send(8'hFC); send(8'hFF); send(8'h01); send(8'h00);
        send(8'h02); send(8'h00);
        chk("t4c_err_pulse", load_error, 1'b1);
        chk("t4c_hold", cpu_hold, 1'b0);
        idle();
        @(negedge clk);
        chk("t4c_err_one_cycle", load_error, 1'b0);
        chk("t4c_writes", wr_n - w0, 0);

        // 5: junk, partial frame, reset mid-payload.
        w0 = wr_n; d0 = done_n; e0 = lerr_n;
        send(8'h12); send(8'h34);
        chk("t5_junk_hold", cpu_hold, 1'b0);
        send(8'hA5);
        send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        send(8'h02); send(8'h00);
        send(8'h44); send(8'h33);
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_hold", cpu_hold, 1'b0);
        chk("t5_rst_ready", bus.rx_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_writes", wr_n - w0, 0);
        chk("t5_pulses", (done_n - d0) + (lerr_n - e0), 0);
        frame1(8'hB8, 1'b1);
        chk("t5_rerun_writes", wr_n - w0, 2);
        chk("t5_rerun_done", done_n - d0, 1);

        // 6: valid held high through frame; ready low exactly in the two WRITE cycles.
        r0 = rdy_low_n;
        frame1(8'hB8, 1'b1);
        chk("t6_rdy_low", rdy_low_n - r0, 2);

        chk("ready_vs_we", rdy_bad_n, 0);
        chk("done_err_overlap", both_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
